alu_arbiter: RTL and testbench



---
 rtl/alu_pkg.sv | 28 ++
 rtl/rr_arb2.sv | 21 ++
 rtl/alu_arbiter.sv | 118 +++++++++++
 tb/tb_alu_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU front end: default widths, op codes and the
// arbiter FSM state type.
package alu_pkg;

   localparam int XLEN_DEF = 32;
   localparam int OPW_DEF  = 4;
   localparam int STW_DEF  = 5;

   // Op code = {funct7[5], funct3}
   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b1000;
   localparam logic [3:0] OP_SLL  = 4'b0001;
   localparam logic [3:0] OP_SLT  = 4'b0010;
   localparam logic [3:0] OP_SLTU = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_SRL  = 4'b0101;
   localparam logic [3:0] OP_SRA  = 4'b1101;
   localparam logic [3:0] OP_OR   = 4'b0110;
   localparam logic [3:0] OP_AND  = 4'b0111;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   // Width of a down-counter that must hold the value lat (never below one bit).
   function automatic int cnt_width(input int lat);
      return (lat < 2) ? 1 : $clog2(lat + 1);
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins, a tie goes to the
// requester that was not served last. Purely combinational.
module rr_arb2 (
   input  logic       valid0,
   input  logic       valid1,
   input  logic       last,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      if (valid0 && valid1) begin
         grant = last ? 2'b01 : 2'b10;
      end else if (valid0) begin
         grant = 2'b01;
      end else if (valid1) begin
         grant = 2'b10;
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one clocked ALU between two requesters. One op in flight at a time;
// operands live in registers owned here so they stay put for the whole ALU latency.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int XLEN    = XLEN_DEF,
   parameter int OPW     = OPW_DEF,
   parameter int STW     = STW_DEF,
   parameter int ALU_LAT = 1
) (
   input  logic            clk,
   input  logic            rst_n,

   input  logic            req0_valid,
   output logic            req0_ready,
   input  logic [XLEN-1:0] req0_a,
   input  logic [XLEN-1:0] req0_b,
   input  logic [OPW-1:0]  req0_op,
   output logic            resp0_valid,
   input  logic            resp0_ready,
   output logic [XLEN-1:0] resp0_result,
   output logic [STW-1:0]  resp0_status,

   input  logic            req1_valid,
   output logic            req1_ready,
   input  logic [XLEN-1:0] req1_a,
   input  logic [XLEN-1:0] req1_b,
   input  logic [OPW-1:0]  req1_op,
   output logic            resp1_valid,
   input  logic            resp1_ready,
   output logic [XLEN-1:0] resp1_result,
   output logic [STW-1:0]  resp1_status,

   output logic [XLEN-1:0] alu_a,
   output logic [XLEN-1:0] alu_b,
   output logic [OPW-1:0]  alu_op,
   input  logic [XLEN-1:0] alu_result,
   input  logic [STW-1:0]  alu_status
);

   localparam int               CNT_W    = cnt_width(ALU_LAT);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ALU_LAT);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             owner;
   logic             last;
   logic [1:0]       grant;

   rr_arb2 u_arb (
      .valid0 (req0_valid),
      .valid1 (req1_valid),
      .last   (last),
      .grant  (grant)
   );

   // Ready looks only at state and the request valids, never at the response side.
   assign req0_ready = (state == IDLE) && grant[0];
   assign req1_ready = (state == IDLE) && grant[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         owner        <= 1'b0;
         last         <= 1'b1;
         alu_a        <= '0;
         alu_b        <= '0;
         alu_op       <= OPW'(OP_ADD);
         resp0_valid  <= 1'b0;
         resp0_result <= '0;
         resp0_status <= '0;
         resp1_valid  <= 1'b0;
         resp1_result <= '0;
         resp1_status <= '0;
      end else begin
         case (state)
            IDLE: begin
               // In IDLE a non-zero grant is exactly the accepting handshake.
               if (grant != 2'b00) begin
                  state  <= WAIT;
                  owner  <= grant[1];
                  last   <= grant[1];
                  cnt    <= CNT_INIT;
                  alu_a  <= grant[1] ? req1_a  : req0_a;
                  alu_b  <= grant[1] ? req1_b  : req0_b;
                  alu_op <= grant[1] ? req1_op : req0_op;
               end
            end
            WAIT: begin
               if (cnt == '0) begin
                  state <= RESP;
                  if (owner) begin
                     resp1_result <= alu_result;
                     resp1_status <= alu_status;
                     resp1_valid  <= 1'b1;
                  end else begin
                     resp0_result <= alu_result;
                     resp0_status <= alu_status;
                     resp0_valid  <= 1'b1;
                  end
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            RESP: begin
               if (owner ? resp1_ready : resp0_ready) begin
                  resp0_valid <= 1'b0;
                  resp1_valid <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: transaction-level reference model plus directed
// scenarios, and a second instance built with a three-cycle ALU.
module tb_alu_arbiter;
   import alu_pkg::*;

   localparam int XLEN = 32, OPW = 4, STW = 5, LAT = 1, LAT3 = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   int nchk  = 0;
   int nfail = 0;

   // ---------------- main DUT (ALU_LAT = 1) ----------------
   logic [1:0]      rv = '0, rr = '0;
   logic [XLEN-1:0] ra [2];
   logic [XLEN-1:0] rb [2];
   logic [OPW-1:0]  rop [2];
   wire  [1:0]      rdy, vld;
   wire  [XLEN-1:0] res0, res1, alu_a, alu_b;
   wire  [STW-1:0]  st0, st1;
   wire  [OPW-1:0]  alu_op;
   logic [XLEN-1:0] alu_r = '0;
   logic [STW-1:0]  alu_s = '0;

   alu_arbiter #(.XLEN(XLEN), .OPW(OPW), .STW(STW), .ALU_LAT(LAT)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(rv[0]), .req0_ready(rdy[0]), .req0_a(ra[0]), .req0_b(rb[0]), .req0_op(rop[0]),
      .resp0_valid(vld[0]), .resp0_ready(rr[0]), .resp0_result(res0), .resp0_status(st0),
      .req1_valid(rv[1]), .req1_ready(rdy[1]), .req1_a(ra[1]), .req1_b(rb[1]), .req1_op(rop[1]),
      .resp1_valid(vld[1]), .resp1_ready(rr[1]), .resp1_result(res1), .resp1_status(st1),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_r), .alu_status(alu_s)
   );

   // ---------------- second DUT (ALU_LAT = 3) ----------------
   logic [1:0]      rv3 = '0, rr3 = '0;
   logic [XLEN-1:0] ra3 [2];
   logic [XLEN-1:0] rb3 [2];
   logic [OPW-1:0]  rop3 [2];
   wire  [1:0]      rdy3, vld3;
   wire  [XLEN-1:0] r3_0, r3_1, alu3_a, alu3_b;
   wire  [STW-1:0]  s3_0, s3_1;
   wire  [OPW-1:0]  alu3_op;
   logic [XLEN-1:0] p3r [3];
   logic [STW-1:0]  p3s [3];

   alu_arbiter #(.XLEN(XLEN), .OPW(OPW), .STW(STW), .ALU_LAT(LAT3)) u_dut3 (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(rv3[0]), .req0_ready(rdy3[0]), .req0_a(ra3[0]), .req0_b(rb3[0]), .req0_op(rop3[0]),
      .resp0_valid(vld3[0]), .resp0_ready(rr3[0]), .resp0_result(r3_0), .resp0_status(s3_0),
      .req1_valid(rv3[1]), .req1_ready(rdy3[1]), .req1_a(ra3[1]), .req1_b(rb3[1]), .req1_op(rop3[1]),
      .resp1_valid(vld3[1]), .resp1_ready(rr3[1]), .resp1_result(r3_1), .resp1_status(s3_1),
      .alu_a(alu3_a), .alu_b(alu3_b), .alu_op(alu3_op), .alu_result(p3r[2]), .alu_status(p3s[2])
   );

   // ---------------- behavioural ALU ----------------
   function automatic logic [31:0] alu_res(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] op);
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_SLL:  return a << b[4:0];
         OP_SLT:  return {31'b0, $signed(a) < $signed(b)};
         OP_SLTU: return {31'b0, a < b};
         OP_XOR:  return a ^ b;
         OP_SRL:  return a >> b[4:0];
         OP_SRA:  return $signed(a) >>> b[4:0];
         OP_OR:   return a | b;
         OP_AND:  return a & b;
         default: return 32'hDEAD_BEEF ^ a;
      endcase
   endfunction

   function automatic logic [4:0] alu_st(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] op);
      logic [31:0] r;
      r = alu_res(a, b, op);
      return {r == 32'd0, r[31], ^r, a == b, op[3]};
   endfunction

   always @(posedge clk) begin
      alu_r  <= alu_res(alu_a, alu_b, alu_op);
      alu_s  <= alu_st(alu_a, alu_b, alu_op);
      p3r[0] <= alu_res(alu3_a, alu3_b, alu3_op);
      p3s[0] <= alu_st(alu3_a, alu3_b, alu3_op);
      p3r[1] <= p3r[0];
      p3s[1] <= p3s[0];
      p3r[2] <= p3r[1];
      p3s[2] <= p3s[1];
   end

   // ---------------- check helpers ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic fail(input string nm, input string why);
      nchk++;
      nfail++;
      $display("FAIL %s: %s (t=%0t)", nm, why, $time);
   endtask

   // ---------------- reference model + scoreboard ----------------
   typedef struct {
      bit          port;
      logic [31:0] res;
      logic [4:0]  st;
   } exp_t;

   exp_t        sb [$];
   bit          m_busy = 1'b0, m_port = 1'b0, m_last = 1'b1;
   int          cyc = 0, m_due = 0;
   logic [31:0] m_a = '0, m_b = '0;
   logic [3:0]  m_op = '0;
   logic [1:0]  m_g;
   logic [1:0]  hs_q = '0;

   // A tie goes to whoever was not served last; otherwise the lone requester wins.
   function automatic logic [1:0] pick(input logic [1:0] v, input bit last_port);
      if (v == 2'b11) return last_port ? 2'b01 : 2'b10;
      return v;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy = 1'b0;
         m_last = 1'b1;
         m_a    = '0;
         m_b    = '0;
         m_op   = OP_ADD;
         cyc    = 0;
         sb.delete();
      end else begin
         if (!m_busy) begin
            m_g = pick(rv, m_last);
            if (m_g != 2'b00) begin
               m_port = m_g[1];
               m_last = m_g[1];
               m_busy = 1'b1;
               m_a    = ra[m_port];
               m_b    = rb[m_port];
               m_op   = rop[m_port];
               m_due  = cyc + LAT + 1;
               sb.push_back('{m_port, alu_res(m_a, m_b, m_op), alu_st(m_a, m_b, m_op)});
            end
         end else if (cyc > m_due && rr[m_port]) begin
            m_busy = 1'b0;
         end
         cyc++;
      end
   end

   always @(negedge clk) begin
      hs_q = rst_n ? (rv & rdy) : 2'b00;
      chk("req_ready", 32'(rdy), 32'(m_busy ? 2'b00 : pick(rv, m_last)));
      chk("resp_valid", 32'(vld), 32'((m_busy && cyc > m_due) ? (2'b01 << m_port) : 2'b00));
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      chk("alu_op", 32'(alu_op), 32'(m_op));
      for (int p = 0; p < 2; p++) begin
         if (vld[p]) begin
            if (sb.size() == 0) begin
               fail("resp_unexpected", "response with nothing outstanding");
            end else begin
               chk("resp_port", 32'(p), 32'(sb[0].port));
               chk("resp_result", p ? res1 : res0, sb[0].res);
               chk("resp_status", 32'(p ? st1 : st0), 32'(sb[0].st));
               if (rr[p]) void'(sb.pop_front());
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   logic [3:0] ops [10];

   task automatic step();
      @(posedge clk);
      #1;
      rv = rv & ~hs_q;
   endtask

   task automatic do_reset();
      rv  = '0;
      rv3 = '0;
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int p, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op);
      ra[p]  = a;
      rb[p]  = b;
      rop[p] = op;
      rv[p]  = 1'b1;
   endtask

   task automatic rand_op(input int p);
      set_op(p, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
             ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
             ($urandom_range(0, 7) == 0) ? 4'($urandom) : ops[$urandom_range(0, 9)]);
   endtask

   task automatic wait_resp(input int p, input logic [31:0] er, input int maxc, input string nm);
      bit got = 1'b0;
      for (int i = 0; i < maxc && !got; i++) begin
         @(negedge clk);
         if (vld[p]) begin
            got = 1'b1;
            chk(nm, p ? res1 : res0, er);
         end
         step();
      end
      if (!got) fail(nm, "timed out waiting for response");
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int gseq [$];
      int seen;
      ops = '{OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND};
      for (int p = 0; p < 2; p++) begin
         ra[p] = '0; rb[p] = '0; rop[p] = '0;
         ra3[p] = '0; rb3[p] = '0; rop3[p] = '0;
      end

      // Reset values
      do_reset();
      @(negedge clk);
      chk("rst_resp_valid", 32'(vld), 32'd0);
      chk("rst_res0", res0, 32'd0);
      chk("rst_res1", res1, 32'd0);
      chk("rst_st0", 32'(st0), 32'd0);
      chk("rst_st1", 32'(st1), 32'd0);
      chk("rst_alu_op", 32'(alu_op), 32'(OP_ADD));

      // Test 1: single request on port 0
      step();
      rr = 2'b11;
      set_op(0, 32'd9, 32'd10, OP_ADD);
      @(negedge clk);
      chk("t1_ready", 32'(rdy), 32'(2'b01));
      step();
      chk("t1_alu_op", 32'(alu_op), 32'(OP_ADD));
      chk("t1_alu_a", alu_a, 32'd9);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("t1_resp_valid", 32'(vld), 32'(2'b01));
      chk("t1_result", res0, 32'd19);
      step();

      // Test 2: simultaneous requests after reset, port 0 wins the first tie
      do_reset();
      rr = 2'b11;
      set_op(0, 32'd9, 32'd10, OP_SUB);
      set_op(1, 32'd1, 32'd1, OP_AND);
      @(negedge clk);
      chk("t2_first_grant", 32'(rdy), 32'(2'b01));
      step();
      wait_resp(0, 32'hFFFF_FFFF, 10, "t2_sub_result");
      wait_resp(1, 32'd1, 10, "t2_and_result");

      // Test 3: back-pressure on port 0 while port 1 waits
      do_reset();
      rr = 2'b10;
      set_op(0, 32'd5, 32'd7, OP_ADD);
      set_op(1, 32'd5, 32'd3, OP_OR);
      wait_resp(0, 32'd12, 10, "t3_result");
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("t3_hold_valid", 32'(vld), 32'(2'b01));
         chk("t3_hold_result", res0, 32'd12);
         chk("t3_hold_status", 32'(st0), 32'(alu_st(32'd5, 32'd7, OP_ADD)));
         chk("t3_ready_low", 32'(rdy), 32'd0);
         step();
      end
      rr[0] = 1'b1;
      @(negedge clk);
      chk("t3_ready_before_consume", 32'(rdy), 32'd0);
      step();
      @(negedge clk);
      chk("t3_accept_next_cycle", 32'(rdy), 32'(2'b10));
      step();
      wait_resp(1, 32'd7, 10, "t3_or_result");

      // Test 4: fairness with port 1 always requesting
      do_reset();
      rr = 2'b11;
      rand_op(1);
      for (int i = 0; i < 80 && gseq.size() < 4; i++) begin
         @(negedge clk);
         if ((rv & rdy) != 2'b00) gseq.push_back(int'(rdy[1]));
         step();
         if (!rv[1]) rand_op(1);
         if (gseq.size() >= 1 && !rv[0]) rand_op(0);
      end
      if (gseq.size() < 4) fail("t4_grants", "fewer than four grants observed");
      for (int i = 0; i < gseq.size() && i < 4; i++)
         chk($sformatf("t4_grant%0d", i), 32'(gseq[i]), 32'((i % 2 == 0) ? 1 : 0));
      rv = '0;
      repeat (8) step();

      // Test 5: asynchronous reset in the middle of WAIT
      do_reset();
      rr = 2'b11;
      set_op(0, 32'd3, 32'd4, OP_ADD);
      @(negedge clk);
      step();
      chk("t5_alu_a_loaded", alu_a, 32'd3);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_rst_alu_a", alu_a, 32'd0);
      chk("t5_rst_alu_b", alu_b, 32'd0);
      chk("t5_rst_alu_op", 32'(alu_op), 32'(OP_ADD));
      chk("t5_rst_valid", 32'(vld), 32'd0);
      chk("t5_rst_res0", res0, 32'd0);
      #2 rst_n = 1'b1;
      seen = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (vld != 2'b00) seen++;
         step();
      end
      chk("t5_no_resp_after_reset", 32'(seen), 32'd0);

      // Random traffic
      for (int i = 0; i < 500; i++) begin
         rr = {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)};
         for (int p = 0; p < 2; p++)
            if (!rv[p] && $urandom_range(0, 2) == 0) rand_op(p);
         step();
      end
      rv = '0;
      rr = 2'b11;
      repeat (12) step();
      chk("drain_outstanding", 32'(sb.size()), 32'd0);

      // Test 6: ALU_LAT = 3 instance
      do_reset();
      rr3 = 2'b01;
      ra3[0] = 32'd10; rb3[0] = 32'd10; rop3[0] = OP_XOR; rv3[0] = 1'b1;
      @(negedge clk);
      chk("t6_ready", 32'(rdy3), 32'(2'b01));
      @(posedge clk);
      #1;
      rv3[0] = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("t6_wait_valid", 32'(vld3), 32'd0);
         chk("t6_alu_a", alu3_a, 32'd10);
         chk("t6_alu_b", alu3_b, 32'd10);
         chk("t6_alu_op", 32'(alu3_op), 32'(OP_XOR));
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      chk("t6_resp_valid", 32'(vld3), 32'(2'b01));
      chk("t6_result", r3_0, 32'd0);
      chk("t6_status", 32'(s3_0), 32'(alu_st(32'd10, 32'd10, OP_XOR)));
      repeat (3) step();

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
